// File: rtl/reg16_write_arbiter.sv
// Arbitrates two requesters for the byte-wide write port of a 16-bit register and
// sequences one or two byte writes from a latched word, pulsing done on completion.
module reg16_write_arbiter #(
  parameter bit HIGH_FIRST = 1'b1,
  parameter bit RR_EN      = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [1:0]  mode0,
  input  logic [15:0] data0,
  output logic        ack0,
  input  logic        req1,
  input  logic [1:0]  mode1,
  input  logic [15:0] data1,
  output logic        ack1,
  output logic        set_high,
  output logic        set_low,
  output logic [7:0]  value,
  output logic        busy,
  output logic        done,
  output logic        done_id
);

  typedef enum logic [1:0] {StIdle, StWr1, StWr2, StDone} state_e;

  state_e      state_q, state_d;
  logic [15:0] word_q, word_d;
  logic [1:0]  mode_q, mode_d;
  logic        id_q, id_d;
  logic        last_grant_q, last_grant_d;
  logic        set_high_q, set_high_d;
  logic        set_low_q, set_low_d;
  logic [7:0]  value_q, value_d;
  logic        done_q, done_d;
  logic        done_id_q, done_id_d;

  logic        req_any;
  logic        win_id;
  logic        first_high;
  logic        idle;

  assign idle    = (state_q == StIdle);
  assign req_any = req0 | req1;
  // On contention, round-robin picks the requester not served last.
  assign win_id  = (req0 & req1) ? (RR_EN ? ~last_grant_q : 1'b0) : req1;

  // Acks are held off while reset is asserted since the accepting edge will be discarded.
  assign ack0 = rst & idle & req0 & ~win_id;
  assign ack1 = rst & idle & req1 & win_id;

  assign busy     = ~idle;
  assign set_high = set_high_q;
  assign set_low  = set_low_q;
  assign value    = value_q;
  assign done     = done_q;
  assign done_id  = done_id_q;

  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    mode_d       = mode_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    set_high_d   = 1'b0;
    set_low_d    = 1'b0;
    value_d      = 8'h00;
    done_d       = 1'b0;
    done_id_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_any) begin
          word_d       = win_id ? data1 : data0;
          mode_d       = win_id ? mode1 : mode0;
          id_d         = win_id;
          last_grant_d = win_id;
          state_d      = (mode_d == 2'b00) ? StDone : StWr1;
        end
      end
      StWr1:   state_d = (mode_q == 2'b11) ? StWr2 : StDone;
      StWr2:   state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Strobes are registered from the word/mode that the next state will work on.
    first_high = (mode_d == 2'b10) | ((mode_d == 2'b11) & HIGH_FIRST);
    unique case (state_d)
      StWr1: begin
        set_high_d = first_high;
        set_low_d  = ~first_high;
        value_d    = first_high ? word_d[15:8] : word_d[7:0];
      end
      StWr2: begin
        set_high_d = ~HIGH_FIRST;
        set_low_d  = HIGH_FIRST;
        value_d    = HIGH_FIRST ? word_d[7:0] : word_d[15:8];
      end
      StDone: begin
        done_d    = 1'b1;
        done_id_d = id_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      word_q       <= 16'h0000;
      mode_q       <= 2'b00;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      set_high_q   <= 1'b0;
      set_low_q    <= 1'b0;
      value_q      <= 8'h00;
      done_q       <= 1'b0;
      done_id_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      mode_q       <= mode_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      set_high_q   <= set_high_d;
      set_low_q    <= set_low_d;
      value_q      <= value_d;
      done_q       <= done_d;
      done_id_q    <= done_id_d;
    end
  end

endmodule

// File: tb/tb_reg16_write_arbiter.sv
// Bench for reg16_write_arbiter: two instances (high-first/round-robin and
// low-first/fixed-priority), a model target register and a completion scoreboard.
module tb_reg16_write_arbiter;

  logic        clk;
  logic        rst;
  logic        req0[2], req1[2], ack0[2], ack1[2];
  logic [1:0]  mode0[2], mode1[2];
  logic [15:0] data0[2], data1[2];
  logic        sh[2], sl[2], busy[2], done[2], did[2];
  logic [7:0]  val[2];

  logic [15:0] mreg[2] = '{16'h0000, 16'h0000};
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  typedef struct {
    logic        id;
    logic [15:0] word;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int g_id[2][8];
  int g_cyc[2][8];
  int g_n[2];

  reg16_write_arbiter #(.HIGH_FIRST(1'b1), .RR_EN(1'b1)) u_dut_a (
    .clk(clk), .rst(rst),
    .req0(req0[0]), .mode0(mode0[0]), .data0(data0[0]), .ack0(ack0[0]),
    .req1(req1[0]), .mode1(mode1[0]), .data1(data1[0]), .ack1(ack1[0]),
    .set_high(sh[0]), .set_low(sl[0]), .value(val[0]),
    .busy(busy[0]), .done(done[0]), .done_id(did[0])
  );

  reg16_write_arbiter #(.HIGH_FIRST(1'b0), .RR_EN(1'b0)) u_dut_b (
    .clk(clk), .rst(rst),
    .req0(req0[1]), .mode0(mode0[1]), .data0(data0[1]), .ack0(ack0[1]),
    .req1(req1[1]), .mode1(mode1[1]), .data1(data1[1]), .ack1(ack1[1]),
    .set_high(sh[1]), .set_low(sl[1]), .value(val[1]),
    .busy(busy[1]), .done(done[1]), .done_id(did[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Target register model: has no reset of its own in this bench.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (sh[k]) mreg[k][15:8] <= val[k];
      if (sl[k]) mreg[k][7:0]  <= val[k];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] merge(input logic [15:0] r, input logic [1:0] m,
                                        input logic [15:0] d);
    logic [15:0] res;
    res = r;
    if (m[1]) res[15:8] = d[15:8];
    if (m[0]) res[7:0] = d[7:0];
    return res;
  endfunction

  task automatic mon(input int k);
    exp_t e;
    logic [1:0] m;
    if (!rst) begin
      if (k == 0) q0.delete(); else q1.delete();
      return;
    end
    check("strobe_excl", {31'd0, sh[k] & sl[k]}, 32'd0);
    check("ack_excl", {31'd0, ack0[k] & ack1[k]}, 32'd0);
    if (ack0[k] | ack1[k]) begin
      m      = ack1[k] ? mode1[k] : mode0[k];
      e.id   = ack1[k];
      e.word = merge(mreg[k], m, ack1[k] ? data1[k] : data0[k]);
      e.lat  = (m == 2'b11) ? 3 : ((m == 2'b00) ? 1 : 2);
      e.acc  = cyc;
      if (k == 0) q0.push_back(e); else q1.push_back(e);
    end
    if (done[k]) begin
      if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
        check("done_unexpected", 32'd1, 32'd0);
      end else begin
        e = (k == 0) ? q0.pop_front() : q1.pop_front();
        check("done_id", {31'd0, did[k]}, {31'd0, e.id});
        check("done_reg", {16'd0, mreg[k]}, {16'd0, e.word});
        check("done_latency", cyc - e.acc, e.lat);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req_go(input int k, input bit id, input logic [1:0] m, input logic [15:0] d);
    bit got;
    got = 1'b0;
    if (id) begin req1[k] = 1'b1; mode1[k] = m; data1[k] = d; end
    else    begin req0[k] = 1'b1; mode0[k] = m; data0[k] = d; end
    #1;
    for (int i = 0; i < 30 && !got; i++) begin
      if (id ? ack1[k] : ack0[k]) got = 1'b1;
      else begin tick(); #1; end
    end
    if (!got) check("ack_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    if (id) req1[k] = 1'b0; else req0[k] = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      if (!busy[0] && !busy[1] && q0.size() == 0 && q1.size() == 0) ok = 1'b1;
    end
    if (!ok) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_out(input int k, input string tag, input logic esh, input logic esl,
                         input logic [7:0] ev);
    @(negedge clk);
    check(tag, {22'd0, sh[k], sl[k], val[k]}, {22'd0, esh, esl, ev});
  endtask

  initial begin
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      req0[k] = 1'b0; req1[k] = 1'b0; mode0[k] = 2'b00; mode1[k] = 2'b00;
      data0[k] = 16'h0000; data1[k] = 16'h0000;
    end
    repeat (3) tick();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("reset_outputs", {25'd0, busy[k], done[k], sh[k], sl[k], ack0[k], ack1[k], did[k]},
            32'd0);
      check("reset_value", {24'd0, val[k]}, 32'd0);
    end
    rst = 1'b1;
    tick();

    // Full word, high byte first
    req_go(0, 1'b0, 2'b11, 16'hA55A);
    chk_out(0, "t1_first_high", 1'b1, 1'b0, 8'hA5);
    chk_out(0, "t1_second_low", 1'b0, 1'b1, 8'h5A);
    wait_idle();
    check("t1_reg", {16'd0, mreg[0]}, 32'h0000A55A);

    // Full word, low byte first, requester 1
    req_go(1, 1'b1, 2'b11, 16'h1234);
    chk_out(1, "t2_first_low", 1'b0, 1'b1, 8'h34);
    chk_out(1, "t2_second_high", 1'b1, 1'b0, 8'h12);
    wait_idle();
    check("t2_reg", {16'd0, mreg[1]}, 32'h00001234);

    // Contention: round-robin on instance a, fixed priority on instance b
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req0[k] = 1'b1; mode0[k] = 2'b11; data0[k] = 16'h1111;
      req1[k] = 1'b1; mode1[k] = 2'b11; data1[k] = 16'h2222;
      g_n[k] = 0;
    end
    for (int i = 0; i < 40 && (g_n[0] < 4 || g_n[1] < 4); i++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if ((ack0[k] | ack1[k]) && g_n[k] < 8) begin
          g_id[k][g_n[k]]  = ack1[k] ? 1 : 0;
          g_cyc[k][g_n[k]] = cyc;
          g_n[k]++;
        end
      end
    end
    tick();
    for (int k = 0; k < 2; k++) begin req0[k] = 1'b0; req1[k] = 1'b0; end
    check("t3_rr_grants", g_n[0], 4);
    check("t3_fp_grants", g_n[1], 4);
    for (int i = 0; i < 4; i++) begin
      check("t3_rr_order", g_id[0][i], i % 2);
      check("t3_fp_order", g_id[1][i], 0);
      if (i > 0) check("t3_rr_spacing", g_cyc[0][i] - g_cyc[0][i-1], 4);
    end
    wait_idle();

    // Single-byte and no-byte writes
    req_go(0, 1'b0, 2'b11, 16'h0011);
    wait_idle();
    req_go(0, 1'b0, 2'b10, 16'hBEEF);
    chk_out(0, "t4_high_only", 1'b1, 1'b0, 8'hBE);
    wait_idle();
    check("t4_reg", {16'd0, mreg[0]}, 32'h0000BE11);
    req_go(0, 1'b0, 2'b00, 16'hFFFF);
    chk_out(0, "t4_no_strobe", 1'b0, 1'b0, 8'h00);
    check("t4_done_t1", {31'd0, done[0]}, 32'd1);
    wait_idle();
    check("t4_reg_kept", {16'd0, mreg[0]}, 32'h0000BE11);

    // Request while busy; data change after acceptance
    req_go(0, 1'b0, 2'b11, 16'hCAFE);
    req1[0] = 1'b1; mode1[0] = 2'b01; data1[0] = 16'h0077;
    data0[0] = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_ack1_busy", {31'd0, ack1[0]}, 32'd0);
    end
    @(negedge clk);
    check("t5_ack1_idle", {31'd0, ack1[0]}, 32'd1);
    tick();
    req1[0] = 1'b0;
    wait_idle();
    check("t5_reg", {16'd0, mreg[0]}, 32'h0000CA77);

    // Reset in the middle of a full-word write
    req_go(0, 1'b0, 2'b11, 16'h1357);
    rst = 1'b0;
    tick();
    @(negedge clk);
    check("t6_busy", {31'd0, busy[0]}, 32'd0);
    check("t6_outputs", {21'd0, sh[0], sl[0], done[0], val[0]}, 32'd0);
    check("t6_partial_reg", {16'd0, mreg[0]}, 32'h00001377);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t6_no_done", {31'd0, done[0]}, 32'd0);
    end
    tick();
    req0[0] = 1'b1; mode0[0] = 2'b11; data0[0] = 16'h2468;
    req1[0] = 1'b1; mode1[0] = 2'b11; data1[0] = 16'h1111;
    #1;
    check("t6_first_grant", {30'd0, ack0[0], ack1[0]}, 32'd2);
    tick();
    req0[0] = 1'b0;
    req1[0] = 1'b0;
    wait_idle();
    check("t6_reg", {16'd0, mreg[0]}, 32'h00002468);

    check("end_queues", q0.size() + q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
